// File: rtl/microseq_next_addr.sv
// -----------------------------------------------------------------------------
// microseq_next_addr
//   Microsequencer for the microprogrammed control unit.
//   - Holds the control address register (CAR).
//   - Picks the next microaddress from one of these sources, under control of
//     the NS field and one selected (optionally inverted) status bit:
//     encoder, literal zero, pipeline branch target, increment, return stack,
//     or hold.
//   - Keeps a LIFO return-address stack for microsubroutine CALL/RET.
//
// Ports
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   NS         in   [3:0]      next-state control field
//   CondSel    in   [CSW-1:0]  status selector into Cond
//   Cond       in   [NCOND-1:0] status flags (out-of-range select reads 0)
//   Inv        in   invert the selected status
//   Enc        in   [AW-1:0]   instruction-encoder address
//   Pipe       in   [AW-1:0]   branch target from the pipeline register
//   Stall      in   1 = freeze CAR, SP, stack contents and StkErr
//   CAR        out  [AW-1:0]   registered current microaddress
//   M          out  [2:0]      source chosen this cycle:
//                              0 enc, 1 zero, 2 pipe, 3 inc, 4 stack, 5 hold
//   StackFull  out  stack holds STACK_DEPTH entries
//   StackEmpty out  stack holds no entries
//   StkErr     out  sticky overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module microseq_next_addr #(
  parameter int AW          = 8,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int CSW = (NCOND > 1) ? $clog2(NCOND) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [3:0]       NS,
  input  logic [CSW-1:0]   CondSel,
  input  logic [NCOND-1:0] Cond,
  input  logic             Inv,
  input  logic [AW-1:0]    Enc,
  input  logic [AW-1:0]    Pipe,
  input  logic             Stall,
  output logic [AW-1:0]    CAR,
  output logic [2:0]       M,
  output logic             StackFull,
  output logic             StackEmpty,
  output logic             StkErr
);

  // SP counts 0..STACK_DEPTH, so it needs one more code than the entry index.
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] M_ENC  = 3'd0;
  localparam logic [2:0] M_ZERO = 3'd1;
  localparam logic [2:0] M_PIPE = 3'd2;
  localparam logic [2:0] M_INC  = 3'd3;
  localparam logic [2:0] M_STK  = 3'd4;
  localparam logic [2:0] M_HOLD = 3'd5;

  logic [AW-1:0]  car_q, car_d;
  logic [SPW-1:0] sp_q;
  logic           err_q;
  logic [AW-1:0]  stk_q [STACK_DEPTH];

  logic [AW-1:0]  inc;
  logic           sts_raw, sts;
  logic           do_call, do_ret;
  logic           push, pop, err_set;
  logic [2:0]     m_sel;
  logic           full, empty;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full   = (sp_q == SPW'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign inc    = car_q + AW'(1);
  // Index truncation is safe: push is blocked when full, pop when empty.
  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - SPW'(1));

  // Status select; any CondSel value with no matching Cond bit reads 0.
  always_comb begin
    sts_raw = 1'b0;
    for (int i = 0; i < NCOND; i++) begin
      if (CondSel == CSW'(i)) sts_raw = Cond[i];
    end
  end
  assign sts = sts_raw ^ Inv;

  always_comb begin
    car_d   = car_q;
    m_sel   = M_HOLD;
    do_call = 1'b0;
    do_ret  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;

    case (NS)
      4'b0000: begin car_d = Enc;  m_sel = M_ENC;  end
      4'b0001: begin car_d = '0;   m_sel = M_ZERO; end
      4'b0010: begin car_d = Pipe; m_sel = M_PIPE; end
      4'b0011: begin car_d = inc;  m_sel = M_INC;  end
      4'b0100: begin
        car_d = sts ? Pipe : Enc;
        m_sel = sts ? M_PIPE : M_ENC;
      end
      4'b0101: begin
        car_d = sts ? Pipe : inc;
        m_sel = sts ? M_PIPE : M_INC;
      end
      4'b0110: begin
        car_d = sts ? Enc : inc;
        m_sel = sts ? M_ENC : M_INC;
      end
      4'b0111: begin car_d = '0; m_sel = M_ZERO; end
      4'b1000: do_call = 1'b1;
      4'b1001: begin
        do_call = sts;
        car_d   = inc;
        m_sel   = M_INC;
      end
      4'b1010: do_ret = 1'b1;
      4'b1011: begin
        do_ret = sts;
        car_d  = inc;
        m_sel  = M_INC;
      end
      4'b1100: begin car_d = car_q; m_sel = M_HOLD; end
      4'b1101: begin
        car_d = sts ? inc : car_q;
        m_sel = sts ? M_INC : M_HOLD;
      end
      default: begin car_d = '0; m_sel = M_ZERO; end
    endcase

    // Overflowing CALL still branches; only the push is dropped.
    if (do_call) begin
      car_d = Pipe;
      m_sel = M_PIPE;
      if (full) err_set = 1'b1;
      else      push    = 1'b1;
    end

    // Underflowing RET restarts the microprogram at RESET_ADDR.
    if (do_ret) begin
      m_sel = M_STK;
      if (empty) begin
        car_d   = AW'(RESET_ADDR);
        err_set = 1'b1;
      end else begin
        car_d = stk_q[rd_idx];
        pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      car_q <= AW'(RESET_ADDR);
      sp_q  <= '0;
      err_q <= 1'b0;
    end else if (!Stall) begin
      car_q <= car_d;
      if (push)     sp_q <= sp_q + SPW'(1);
      else if (pop) sp_q <= sp_q - SPW'(1);
      if (err_set)  err_q <= 1'b1;
    end
  end

  // Stack contents need no reset; SP alone defines which entries are valid.
  always_ff @(posedge Clk) begin
    if (!Stall && push) stk_q[wr_idx] <= inc;
  end

  assign CAR        = car_q;
  assign M          = m_sel;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign StkErr     = err_q;

endmodule

// File: tb/tb_microseq_next_addr.sv
module tb_microseq_next_addr;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] NS;
  logic [1:0] CondSel;
  logic [3:0] Cond;
  logic       Inv;
  logic [7:0] Enc;
  logic [7:0] Pipe;
  logic       Stall;
  logic [7:0] CAR;
  logic [2:0] M;
  logic       StackFull;
  logic       StackEmpty;
  logic       StkErr;

  int n_tests = 0;
  int n_fail  = 0;

  microseq_next_addr #(
    .AW(8), .NCOND(4), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .NS(NS), .CondSel(CondSel), .Cond(Cond),
    .Inv(Inv), .Enc(Enc), .Pipe(Pipe), .Stall(Stall), .CAR(CAR), .M(M),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .StkErr(StkErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    #1;
  endtask

  task automatic load_car(input logic [7:0] a);
    NS   = 4'b0010;
    Pipe = a;
    step();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; NS = 4'b0000; CondSel = '0; Cond = '0; Inv = 1'b0;
    Enc = '0; Pipe = '0; Stall = 1'b0;
    #3;
    n_tests++;
    if (CAR !== 8'h00) begin n_fail++; $display("FAIL reset_car: got %h want 00", CAR); end
    n_tests++;
    if (StackEmpty !== 1'b1 || StackFull !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", StackEmpty, StackFull);
    end
    n_tests++;
    if (StkErr !== 1'b0) begin n_fail++; $display("FAIL reset_stkerr: got %b want 0", StkErr); end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp;
    do_reset();
    NS = 4'b0011;
    #1;
    n_tests++;
    if (M !== 3'd3) begin n_fail++; $display("FAIL inc_m: got %0d want 3", M); end
    for (int i = 0; i < 260; i++) begin
      step();
      exp = 8'((i + 1) % 256);
      n_tests++;
      if (CAR !== exp) begin n_fail++; $display("FAIL inc_wrap[%0d]: got %h want %h", i, CAR, exp); end
    end
  endtask

  task automatic test_legacy();
    do_reset();
    Enc = 8'h40; CondSel = 2'd0; Cond = 4'b0000;

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0100; Inv = 1'b0; #1;
    n_tests++;
    if (M !== 3'd0) begin n_fail++; $display("FAIL legacy_0100_s0_m: got %0d want 0", M); end
    step();
    n_tests++;
    if (CAR !== 8'h40) begin n_fail++; $display("FAIL legacy_0100_s0: got %h want 40", CAR); end

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0100; Inv = 1'b1; #1;
    n_tests++;
    if (M !== 3'd2) begin n_fail++; $display("FAIL legacy_0100_s1_m: got %0d want 2", M); end
    step();
    n_tests++;
    if (CAR !== 8'h80) begin n_fail++; $display("FAIL legacy_0100_s1: got %h want 80", CAR); end

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0110; Inv = 1'b0; #1;
    n_tests++;
    if (M !== 3'd3) begin n_fail++; $display("FAIL legacy_0110_s0_m: got %0d want 3", M); end
    step();
    n_tests++;
    if (CAR !== 8'h11) begin n_fail++; $display("FAIL legacy_0110_s0: got %h want 11", CAR); end

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0110; Inv = 1'b1; step();
    n_tests++;
    if (CAR !== 8'h40) begin n_fail++; $display("FAIL legacy_0110_s1: got %h want 40", CAR); end

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0101; Inv = 1'b0; step();
    n_tests++;
    if (CAR !== 8'h11) begin n_fail++; $display("FAIL legacy_0101_s0: got %h want 11", CAR); end

    load_car(8'h10); Pipe = 8'h80; NS = 4'b0101; Inv = 1'b1; step();
    n_tests++;
    if (CAR !== 8'h80) begin n_fail++; $display("FAIL legacy_0101_s1: got %h want 80", CAR); end

    load_car(8'h10); NS = 4'b0111; Inv = 1'b0; #1;
    n_tests++;
    if (M !== 3'd1) begin n_fail++; $display("FAIL legacy_0111_m: got %0d want 1", M); end
    step();
    n_tests++;
    if (CAR !== 8'h00) begin n_fail++; $display("FAIL legacy_0111: got %h want 00", CAR); end

    load_car(8'h10); NS = 4'b0000; step();
    n_tests++;
    if (CAR !== 8'h40) begin n_fail++; $display("FAIL legacy_0000: got %h want 40", CAR); end

    load_car(8'h10); NS = 4'b0001; step();
    n_tests++;
    if (CAR !== 8'h00) begin n_fail++; $display("FAIL legacy_0001: got %h want 00", CAR); end

    load_car(8'h10); NS = 4'b1110; #1;
    n_tests++;
    if (M !== 3'd1) begin n_fail++; $display("FAIL reserved_m: got %0d want 1", M); end
    step();
    n_tests++;
    if (CAR !== 8'h00 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL reserved_1110: car=%h empty=%b want 00 1", CAR, StackEmpty);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    Inv = 1'b0; Cond = '0;
    load_car(8'h20);
    NS = 4'b1000; Pipe = 8'h50; #1;
    n_tests++;
    if (M !== 3'd2) begin n_fail++; $display("FAIL call_m: got %0d want 2", M); end
    step();
    n_tests++;
    if (CAR !== 8'h50 || StackEmpty !== 1'b0 || StackFull !== 1'b0) begin
      n_fail++; $display("FAIL call: car=%h empty=%b full=%b want 50 0 0", CAR, StackEmpty, StackFull);
    end
    NS = 4'b1010; #1;
    n_tests++;
    if (M !== 3'd4) begin n_fail++; $display("FAIL ret_m: got %0d want 4", M); end
    step();
    n_tests++;
    if (CAR !== 8'h21 || StackEmpty !== 1'b1 || StkErr !== 1'b0) begin
      n_fail++; $display("FAIL ret: car=%h empty=%b err=%b want 21 1 0", CAR, StackEmpty, StkErr);
    end
  endtask

  task automatic test_cond_stack();
    do_reset();
    CondSel = 2'd1; Cond = 4'b0000; Inv = 1'b0;
    load_car(8'h60);
    NS = 4'b1001; Pipe = 8'h90; step();
    n_tests++;
    if (CAR !== 8'h61 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL ccall_nt: car=%h empty=%b want 61 1", CAR, StackEmpty);
    end
    Cond = 4'b0010; step();
    n_tests++;
    if (CAR !== 8'h90 || StackEmpty !== 1'b0) begin
      n_fail++; $display("FAIL ccall_t: car=%h empty=%b want 90 0", CAR, StackEmpty);
    end
    Cond = 4'b0000; NS = 4'b1011; step();
    n_tests++;
    if (CAR !== 8'h91 || StackEmpty !== 1'b0) begin
      n_fail++; $display("FAIL cret_nt: car=%h empty=%b want 91 0", CAR, StackEmpty);
    end
    Cond = 4'b0010; step();
    n_tests++;
    if (CAR !== 8'h62 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL cret_t: car=%h empty=%b want 62 1", CAR, StackEmpty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] tgt [5];
    logic [7:0] ret [4];
    tgt[0] = 8'h30; tgt[1] = 8'h40; tgt[2] = 8'h50; tgt[3] = 8'h60; tgt[4] = 8'h70;
    ret[0] = 8'h51; ret[1] = 8'h41; ret[2] = 8'h31; ret[3] = 8'h11;
    do_reset();
    Inv = 1'b0; Cond = '0;
    load_car(8'h10);
    for (int i = 0; i < 5; i++) begin
      NS = 4'b1000; Pipe = tgt[i]; step();
      n_tests++;
      if (CAR !== tgt[i]) begin n_fail++; $display("FAIL ovf_call[%0d]: got %h want %h", i, CAR, tgt[i]); end
      n_tests++;
      if (StackFull !== (i >= 3) || StkErr !== (i == 4)) begin
        n_fail++; $display("FAIL ovf_flags[%0d]: full=%b err=%b want %b %b", i, StackFull, StkErr, i >= 3, i == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      NS = 4'b1010; step();
      n_tests++;
      if (CAR !== ret[i]) begin n_fail++; $display("FAIL ovf_ret[%0d]: got %h want %h", i, CAR, ret[i]); end
    end
    n_tests++;
    if (StackEmpty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", StackEmpty); end
    NS = 4'b1010; #1;
    n_tests++;
    if (M !== 3'd4) begin n_fail++; $display("FAIL udf_m: got %0d want 4", M); end
    step();
    n_tests++;
    if (CAR !== 8'h00 || StkErr !== 1'b1 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL udf: car=%h err=%b empty=%b want 00 1 1", CAR, StkErr, StackEmpty);
    end
  endtask

  task automatic test_wait_hold();
    do_reset();
    load_car(8'h33);
    NS = 4'b1101; CondSel = 2'd2; Inv = 1'b1; Cond = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (M !== 3'd5) begin n_fail++; $display("FAIL wait_m[%0d]: got %0d want 5", i, M); end
      step();
      n_tests++;
      if (CAR !== 8'h33) begin n_fail++; $display("FAIL wait_hold[%0d]: got %h want 33", i, CAR); end
    end
    Cond = 4'b0000; #1;
    n_tests++;
    if (M !== 3'd3) begin n_fail++; $display("FAIL wait_go_m: got %0d want 3", M); end
    step();
    n_tests++;
    if (CAR !== 8'h34) begin n_fail++; $display("FAIL wait_go: got %h want 34", CAR); end
    NS = 4'b1100; step(); step();
    n_tests++;
    if (CAR !== 8'h34 || M !== 3'd5) begin
      n_fail++; $display("FAIL hold: car=%h m=%0d want 34 5", CAR, M);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    Inv = 1'b0; Cond = '0;
    load_car(8'h20);
    Stall = 1'b1; NS = 4'b1000; Pipe = 8'h50; #1;
    n_tests++;
    if (M !== 3'd2) begin n_fail++; $display("FAIL stall_m: got %0d want 2", M); end
    step(); step();
    n_tests++;
    if (CAR !== 8'h20 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: car=%h empty=%b want 20 1", CAR, StackEmpty);
    end
    Stall = 1'b0; step();
    n_tests++;
    if (CAR !== 8'h50 || StackEmpty !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: car=%h empty=%b want 50 0", CAR, StackEmpty);
    end
    NS = 4'b1010; step();
    step();
    n_tests++;
    if (CAR !== 8'h00 || StkErr !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_udf: car=%h err=%b want 00 1", CAR, StkErr);
    end
    NS = 4'b1000; Pipe = 8'h77; step();
    n_tests++;
    if (CAR !== 8'h77 || StackEmpty !== 1'b0) begin
      n_fail++; $display("FAIL pre_rst_call: car=%h empty=%b want 77 0", CAR, StackEmpty);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if (CAR !== 8'h00 || StackEmpty !== 1'b1 || StkErr !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: car=%h empty=%b err=%b want 00 1 0", CAR, StackEmpty, StkErr);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_legacy();
    test_call_ret();
    test_cond_stack();
    test_overflow();
    test_wait_hold();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
